apb_slave_regfile: RTL and testbench

- APB3 slave register bank; sits directly downstream of the AHB-to-APB bridge and is the target its APB transfers terminate on.
- Provides NUM_REGS word registers, programmable wait states via PREADY, a read-only completed-transfer counter, and optional PSLVERR on illegal accesses.
- Serves as the bridge's bench target and as a template for real peripherals.

---
 rtl/apb_slave_regfile_if.sv | 24 ++
 rtl/apb_slave_regfile.sv | 194 +++++++++++++++++++
 tb/tb_apb_slave_regfile.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle between the AHB-to-APB bridge (master) and the register bank (slave).
interface apb_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB3 slave register bank: WAIT_CFG, general registers, read-only XFER_CNT, programmable wait states.
// Optional error response on illegal accesses is enabled by defining APB_SLV_PSLVERR_EN.
module apb_slave_regfile #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000
) (
    input  logic                hclk,
    input  logic                hreset_n,
    apb_slave_regfile_if.slave  bus
);
    localparam int                    IDX_W   = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0]      CNT_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] SPAN    = ADDR_WIDTH'(4 * NUM_REGS);
    localparam logic [DATA_WIDTH-1:0] ONE     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ZERO    = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    state_t                phase_s;

    logic [ADDR_WIDTH-1:0] offset_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  err_s;
    logic [DATA_WIDTH-1:0] rd_now_s;
    logic [DATA_WIDTH-1:0] rd_late_s;

    logic [IDX_W-1:0]      idx_r;
    logic                  wr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  err_r;
    logic [3:0]            cnt_r;
    logic                  pready_r;
    logic [DATA_WIDTH-1:0] prdata_r;
    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

    logic [3:0]            cnt_nxt_s;
    logic                  pready_nxt_s;
    logic [DATA_WIDTH-1:0] prdata_nxt_s;
    logic                  commit_s;

    // Address decode of the live bus and read-data selection for both response points.
    always_comb begin
        offset_s = bus.paddr - BASE_ADDR;
        idx_s    = offset_s[IDX_W+1:2];
        if ((bus.paddr[1:0] != 2'b00) || (bus.paddr < BASE_ADDR) || (offset_s >= SPAN)) begin
            err_s = 1'b1;
        end else if (bus.pwrite && (idx_s == CNT_IDX)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
        rd_now_s  = (bus.pwrite || err_s) ? ZERO : regs_r[idx_s];
        rd_late_s = (wr_r || err_r) ? ZERO : regs_r[idx_r];
    end

    // Current phase and next state. SETUP is recognised in the cycle the master presents it,
    // so the registered state only ever holds IDLE or ACCESS.
    always_comb begin
        phase_s      = state_r;
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    phase_s      = ST_SETUP;
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!bus.psel) begin
                    next_state_s = ST_IDLE;
                end else if (bus.penable && pready_r) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            default: begin
                phase_s      = ST_IDLE;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Wait counter, pready and read data: pready rises once the counter has run out.
    always_comb begin
        cnt_nxt_s    = cnt_r;
        pready_nxt_s = 1'b0;
        prdata_nxt_s = ZERO;
        commit_s     = 1'b0;
        case (phase_s)
            ST_SETUP: begin
                cnt_nxt_s    = regs_r[0][3:0];
                pready_nxt_s = (regs_r[0][3:0] == 4'd0);
                prdata_nxt_s = (regs_r[0][3:0] == 4'd0) ? rd_now_s : ZERO;
            end
            ST_ACCESS: begin
                if (!bus.psel) begin
                    cnt_nxt_s = 4'd0;
                end else if (pready_r) begin
                    if (bus.penable) begin
                        commit_s = !err_r;
                    end else begin
                        pready_nxt_s = 1'b1;
                        prdata_nxt_s = rd_late_s;
                    end
                end else begin
                    cnt_nxt_s    = cnt_r - 4'd1;
                    pready_nxt_s = (cnt_r == 4'd1);
                    prdata_nxt_s = (cnt_r == 4'd1) ? rd_late_s : ZERO;
                end
            end
            default: begin
                cnt_nxt_s = cnt_r;
            end
        endcase
    end

    // Transfer latches, response registers and the register bank itself.
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            idx_r    <= {IDX_W{1'b0}};
            wr_r     <= 1'b0;
            wdata_r  <= ZERO;
            err_r    <= 1'b0;
            cnt_r    <= 4'd0;
            pready_r <= 1'b0;
            prdata_r <= ZERO;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= ZERO;
            end
        end else begin
            cnt_r    <= cnt_nxt_s;
            pready_r <= pready_nxt_s;
            prdata_r <= prdata_nxt_s;
            if (phase_s == ST_SETUP) begin
                idx_r   <= idx_s;
                wr_r    <= bus.pwrite;
                wdata_r <= bus.pwdata;
                err_r   <= err_s;
            end
            if (commit_s) begin
                if (wr_r) begin
                    if (idx_r == {IDX_W{1'b0}}) begin
                        regs_r[0] <= {{(DATA_WIDTH-4){1'b0}}, wdata_r[3:0]};
                    end else begin
                        regs_r[idx_r] <= wdata_r;
                    end
                end
                regs_r[CNT_IDX] <= regs_r[CNT_IDX] + ONE;
            end
        end
    end

    assign bus.pready = pready_r;
    assign bus.prdata = prdata_r;

`ifdef APB_SLV_PSLVERR_EN
    logic pslverr_r;

    // Error flag travels with pready for illegal accesses.
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            pslverr_r <= 1'b0;
        end else if (pready_nxt_s) begin
            pslverr_r <= (phase_s == ST_SETUP) ? err_s : err_r;
        end else begin
            pslverr_r <= 1'b0;
        end
    end

    assign bus.pslverr = pslverr_r;
`else
    assign bus.pslverr = 1'b0;
`endif
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed self-checking bench for apb_slave_regfile; expected values are hand-computed per scenario.
module tb_apb_slave_regfile;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic hclk;
    logic hreset_n;
    int   tests;
    int   fails;
    logic exp_err;

    apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_slave_regfile dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus.slave)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // Bus driver: starts the setup phase immediately (caller sits 1 time unit after an edge),
    // returns 1 time unit after the completion edge with the bus released.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        @(posedge hclk); #1;
        bus.penable = 1'b1;
        waits = 0;
        while (bus.pready !== 1'b1) begin
            waits++;
            if (waits > 40) begin
                tests++; fails++;
                $display("FAIL xfer_timeout: addr %h pready %b after %0d cycles, required 1", addr, bus.pready, waits);
                break;
            end
            @(posedge hclk); #1;
        end
        rdata = bus.prdata;
        err   = bus.pslverr;
        @(posedge hclk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic do_reset();
        hreset_n    = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        hreset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int w; logic [31:0] exp;
        hreset_n = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
        tests++; if (bus.pready !== 1'b0) begin fails++; $display("FAIL reset_pready: got %b expected 0", bus.pready); end
        tests++; if (bus.prdata !== 32'h0) begin fails++; $display("FAIL reset_prdata: got %h expected 0", bus.prdata); end
        tests++; if (bus.pslverr !== 1'b0) begin fails++; $display("FAIL reset_pslverr: got %b expected 0", bus.pslverr); end
        hreset_n = 1'b1;
        @(posedge hclk); #1;
        for (int i = 0; i < 16; i++) begin
            apb_xfer(1'b0, BASE + 32'(4 * i), 32'h0, rd, er, w);
            exp = (i == 15) ? 32'd15 : 32'd0;
            tests++; if (rd !== exp) begin fails++; $display("FAIL reset_read[%0d]: got %h expected %h", i, rd, exp); end
            tests++; if (er !== 1'b0) begin fails++; $display("FAIL reset_err[%0d]: got %b expected 0", i, er); end
            tests++; if (w != 0) begin fails++; $display("FAIL reset_waits[%0d]: got %0d expected 0", i, w); end
        end
    endtask

    task automatic test_rw();
        logic [31:0] rd; logic er; int w;
        do_reset();
        apb_xfer(1'b1, BASE + 32'h08, 32'hA5A5_5A5A, rd, er, w);
        apb_xfer(1'b0, BASE + 32'h08, 32'h0, rd, er, w);
        tests++; if (rd !== 32'hA5A5_5A5A) begin fails++; $display("FAIL rw_reg2: got %h expected a5a55a5a", rd); end
        apb_xfer(1'b0, BASE + 32'h3C, 32'h0, rd, er, w);
        tests++; if (rd !== 32'd2) begin fails++; $display("FAIL rw_cnt2: got %h expected 2", rd); end
        apb_xfer(1'b1, BASE + 32'h04, 32'hDEAD_BEEF, rd, er, w);
        apb_xfer(1'b1, BASE + 32'h38, 32'h0123_4567, rd, er, w);
        apb_xfer(1'b0, BASE + 32'h04, 32'h0, rd, er, w);
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rw_reg1: got %h expected deadbeef", rd); end
        apb_xfer(1'b0, BASE + 32'h38, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0123_4567) begin fails++; $display("FAIL rw_reg14: got %h expected 01234567", rd); end
        apb_xfer(1'b1, BASE + 32'h00, 32'hFFFF_FFF0, rd, er, w);
        apb_xfer(1'b0, BASE + 32'h00, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rw_waitcfg_mask: got %h expected 0", rd); end
        apb_xfer(1'b0, BASE + 32'h3C, 32'h0, rd, er, w);
        tests++; if (rd !== 32'd9) begin fails++; $display("FAIL rw_cnt9: got %h expected 9", rd); end
    endtask

    task automatic test_wait();
        logic [31:0] rd; logic er; int w;
        apb_xfer(1'b1, BASE + 32'h00, 32'h3, rd, er, w);
        tests++; if (w != 0) begin fails++; $display("FAIL wait_cfg_write_waits: got %0d expected 0", w); end
        apb_xfer(1'b0, BASE + 32'h08, 32'h0, rd, er, w);
        tests++; if (w != 3) begin fails++; $display("FAIL wait_read_waits: got %0d expected 3", w); end
        tests++; if (rd !== 32'hA5A5_5A5A) begin fails++; $display("FAIL wait_read_data: got %h expected a5a55a5a", rd); end
        apb_xfer(1'b0, BASE + 32'h00, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0000_0003) begin fails++; $display("FAIL wait_cfg_read: got %h expected 3", rd); end
        apb_xfer(1'b1, BASE + 32'h00, 32'h0, rd, er, w);
        tests++; if (w != 3) begin fails++; $display("FAIL wait_cfg_clear_waits: got %0d expected 3", w); end
        apb_xfer(1'b0, BASE + 32'h08, 32'h0, rd, er, w);
        tests++; if (w != 0) begin fails++; $display("FAIL wait_after_clear: got %0d expected 0", w); end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic er; int w;
        do_reset();
        apb_xfer(1'b1, BASE + 32'h40, 32'h1, rd, er, w);
        tests++; if (er !== exp_err) begin fails++; $display("FAIL ill_past_end: got %b expected %b", er, exp_err); end
        tests++; if (w != 0) begin fails++; $display("FAIL ill_past_end_waits: got %0d expected 0", w); end
        apb_xfer(1'b1, BASE + 32'h06, 32'hFFFF, rd, er, w);
        tests++; if (er !== exp_err) begin fails++; $display("FAIL ill_misaligned: got %b expected %b", er, exp_err); end
        apb_xfer(1'b1, BASE + 32'h3C, 32'h55, rd, er, w);
        tests++; if (er !== exp_err) begin fails++; $display("FAIL ill_cnt_write: got %b expected %b", er, exp_err); end
        apb_xfer(1'b1, 32'h3FFF_FFFC, 32'h7, rd, er, w);
        tests++; if (er !== exp_err) begin fails++; $display("FAIL ill_below_base: got %b expected %b", er, exp_err); end
        apb_xfer(1'b1, BASE + 32'h02, 32'h3, rd, er, w);
        tests++; if (er !== exp_err) begin fails++; $display("FAIL ill_misaligned_cfg: got %b expected %b", er, exp_err); end
        apb_xfer(1'b0, BASE + 32'h40, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL ill_read_data: got %h expected 0", rd); end
        tests++; if (er !== exp_err) begin fails++; $display("FAIL ill_read_err: got %b expected %b", er, exp_err); end
        apb_xfer(1'b0, BASE + 32'h3C, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL ill_cnt_value: got %h expected 0", rd); end
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL ill_legal_err: got %b expected 0", er); end
        apb_xfer(1'b0, BASE + 32'h04, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL ill_reg1_kept: got %h expected 0", rd); end
        apb_xfer(1'b0, BASE + 32'h00, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL ill_cfg_kept: got %h expected 0", rd); end
        tests++; if (w != 0) begin fails++; $display("FAIL ill_cfg_waits: got %0d expected 0", w); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int w;
        do_reset();
        apb_xfer(1'b1, BASE + 32'h10, 32'h0000_AAAA, rd, er, w);
        apb_xfer(1'b1, BASE + 32'h00, 32'h5, rd, er, w);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = BASE + 32'h10; bus.pwdata = 32'h0000_1234;
        @(posedge hclk); #1;
        bus.penable = 1'b1;
        tests++; if (bus.pready !== 1'b0) begin fails++; $display("FAIL abort_access1: got %b expected 0", bus.pready); end
        @(posedge hclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        repeat (6) begin
            @(posedge hclk); #1;
        end
        tests++; if (bus.pready !== 1'b0) begin fails++; $display("FAIL abort_pready: got %b expected 0", bus.pready); end
        apb_xfer(1'b0, BASE + 32'h10, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0000_AAAA) begin fails++; $display("FAIL abort_kept: got %h expected 0000aaaa", rd); end
        tests++; if (w != 5) begin fails++; $display("FAIL abort_next_waits: got %0d expected 5", w); end
        apb_xfer(1'b0, BASE + 32'h3C, 32'h0, rd, er, w);
        tests++; if (rd !== 32'd3) begin fails++; $display("FAIL abort_cnt: got %h expected 3", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int w;
        logic [31:0] addrs [3];
        addrs[0] = BASE + 32'h0C; addrs[1] = BASE + 32'h14; addrs[2] = BASE + 32'h18;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apb_xfer(1'b1, addrs[i], 32'(i + 1), rd, er, w);
        end
        for (int i = 0; i < 3; i++) begin
            apb_xfer(1'b0, addrs[i], 32'h0, rd, er, w);
            tests++; if (rd !== 32'(i + 1)) begin fails++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rd, 32'(i + 1)); end
            tests++; if (w != 0) begin fails++; $display("FAIL b2b_waits[%0d]: got %0d expected 0", i, w); end
        end
        apb_xfer(1'b0, BASE + 32'h3C, 32'h0, rd, er, w);
        tests++; if (rd !== 32'd6) begin fails++; $display("FAIL b2b_cnt: got %h expected 6", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int w;
        apb_xfer(1'b1, BASE + 32'h00, 32'h4, rd, er, w);
        apb_xfer(1'b1, BASE + 32'h08, 32'h0000_1111, rd, er, w);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = BASE + 32'h0C; bus.pwdata = 32'h0000_BEEF;
        @(posedge hclk); #1;
        bus.penable = 1'b1;
        @(posedge hclk); #1;
        hreset_n = 1'b0;
        @(posedge hclk); #1;
        hreset_n = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        tests++; if (bus.pready !== 1'b0) begin fails++; $display("FAIL rstmid_pready: got %b expected 0", bus.pready); end
        apb_xfer(1'b0, BASE + 32'h3C, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rstmid_cnt: got %h expected 0", rd); end
        tests++; if (w != 0) begin fails++; $display("FAIL rstmid_waits: got %0d expected 0", w); end
        apb_xfer(1'b0, BASE + 32'h00, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rstmid_cfg: got %h expected 0", rd); end
        apb_xfer(1'b0, BASE + 32'h08, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rstmid_reg2: got %h expected 0", rd); end
        apb_xfer(1'b0, BASE + 32'h0C, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rstmid_lost_write: got %h expected 0", rd); end
    endtask

    task automatic test_idle_penable();
        logic [31:0] rd; logic er; int w;
        do_reset();
        bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1;
        bus.paddr = BASE + 32'h08; bus.pwdata = 32'h0000_0077;
        repeat (3) begin
            @(posedge hclk); #1;
        end
        tests++; if (bus.pready !== 1'b0) begin fails++; $display("FAIL idlepen_pready: got %b expected 0", bus.pready); end
        bus.psel = 1'b0; bus.penable = 1'b0;
        apb_xfer(1'b0, BASE + 32'h08, 32'h0, rd, er, w);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL idlepen_reg2: got %h expected 0", rd); end
        apb_xfer(1'b0, BASE + 32'h3C, 32'h0, rd, er, w);
        tests++; if (rd !== 32'd1) begin fails++; $display("FAIL idlepen_cnt: got %h expected 1", rd); end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        hreset_n    = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'h0;
        bus.pwdata  = 32'h0;
`ifdef APB_SLV_PSLVERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        test_reset();
        test_rw();
        test_wait();
        test_illegal();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_idle_penable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
